// File: rtl/player_move_ctrl.sv
// player_move_ctrl: sequences a map read per move request, hands the
// target tile to mux_tiles and commits the position/key count it returns.
// Optional feature: define STEP_COUNTER_EN to enable the step_count counter
// (otherwise step_count is tied to zero).
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   move_req, move_dir          1-cycle move pulse, 0=up 1=down 2=left 3=right
//   busy, move_done             FSM not idle / move committed pulse
//   map_rd_addr, map_rd_data    {y,x} read address, tile id returned next cycle
//   map_wr_en/_addr/_data       floor write-back over a collected key
//   tile_id, pos_x, pos_y       latched target tile and coordinates
//   player_x, player_y, key_num committed player state
//   goto_x, goto_y, key_num_in  resolution from mux_tiles
//   step_count                  successful-move counter
module player_move_ctrl #(
    parameter int          MAP_W      = 16,
    parameter int          MAP_H      = 16,
    parameter int          START_X    = 1,
    parameter int          START_Y    = 1,
    parameter logic [15:0] FLOOR_TILE = 16'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        move_req,
    input  logic [1:0]  move_dir,
    output logic        busy,
    output logic        move_done,
    output logic [7:0]  map_rd_addr,
    input  logic [15:0] map_rd_data,
    output logic        map_wr_en,
    output logic [7:0]  map_wr_addr,
    output logic [15:0] map_wr_data,
    output logic [15:0] tile_id,
    output logic [3:0]  pos_x,
    output logic [3:0]  pos_y,
    output logic [3:0]  player_x,
    output logic [3:0]  player_y,
    output logic [3:0]  key_num,
    input  logic [3:0]  goto_x,
    input  logic [3:0]  goto_y,
    input  logic [3:0]  key_num_in,
    output logic [15:0] step_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  player_x_q, player_x_d;
    logic [3:0]  player_y_q, player_y_d;
    logic [3:0]  key_num_q, key_num_d;
    logic [15:0] tile_id_q, tile_id_d;
    logic [3:0]  pos_x_q, pos_x_d;
    logic [3:0]  pos_y_q, pos_y_d;
    logic [7:0]  rd_addr_q, rd_addr_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic        done_q, done_d;

    logic [3:0]  tx, ty;
    logic        tgt_ok;
    logic        key_wrap;
    logic        key_chg;

    // Target tile and edge check for the requested direction.
    always_comb begin
        tx     = player_x_q;
        ty     = player_y_q;
        tgt_ok = 1'b0;
        case (move_dir)
            2'd0: begin
                ty     = player_y_q - 4'd1;
                tgt_ok = (player_y_q != 4'd0);
            end
            2'd1: begin
                ty     = player_y_q + 4'd1;
                tgt_ok = (int'(player_y_q) < MAP_H - 1);
            end
            2'd2: begin
                tx     = player_x_q - 4'd1;
                tgt_ok = (player_x_q != 4'd0);
            end
            default: begin
                tx     = player_x_q + 4'd1;
                tgt_ok = (int'(player_x_q) < MAP_W - 1);
            end
        endcase
    end

    // mux_tiles counts keys in 4 bits; 15 -> 0 is an overflow we refuse.
    assign key_wrap = (key_num_q == 4'hF) && (key_num_in == 4'h0);
    assign key_chg  = (key_num_in != key_num_q) && !key_wrap;

    always_comb begin
        state_d    = state_q;
        player_x_d = player_x_q;
        player_y_d = player_y_q;
        key_num_d  = key_num_q;
        tile_id_d  = tile_id_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        rd_addr_d  = rd_addr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (move_req && tgt_ok) begin
                    pos_x_d   = tx;
                    pos_y_d   = ty;
                    rd_addr_d = {ty, tx};
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                tile_id_d = map_rd_data;
                state_d   = RESOLVE;
            end
            RESOLVE: begin
                player_x_d = goto_x;
                player_y_d = goto_y;
                if (!key_wrap) begin
                    key_num_d = key_num_in;
                end
                if (key_chg) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {pos_y_q, pos_x_q};
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            player_x_q <= 4'(START_X);
            player_y_q <= 4'(START_Y);
            key_num_q  <= 4'd0;
            tile_id_q  <= 16'd0;
            pos_x_q    <= 4'd0;
            pos_y_q    <= 4'd0;
            rd_addr_q  <= 8'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 8'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            player_x_q <= player_x_d;
            player_y_q <= player_y_d;
            key_num_q  <= key_num_d;
            tile_id_q  <= tile_id_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            rd_addr_q  <= rd_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            done_q     <= done_d;
        end
    end

`ifdef STEP_COUNTER_EN
    logic [15:0] step_q, step_d;

    always_comb begin
        step_d = step_q;
        if (state_q == RESOLVE &&
            (goto_x != player_x_q || goto_y != player_y_q) &&
            step_q != 16'hFFFF) begin
            step_d = step_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 16'd0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step_count = step_q;
`else
    assign step_count = 16'd0;
`endif

    assign busy        = (state_q != IDLE);
    assign move_done   = done_q;
    assign map_rd_addr = rd_addr_q;
    assign map_wr_en   = wr_en_q;
    assign map_wr_addr = wr_addr_q;
    assign map_wr_data = FLOOR_TILE;
    assign tile_id     = tile_id_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign player_x    = player_x_q;
    assign player_y    = player_y_q;
    assign key_num     = key_num_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Testbench for player_move_ctrl: random walk over a random tile map with
// a queued scoreboard checked by a monitor on every move_done.
module tb_player_move_ctrl;

    localparam logic [15:0] FLOOR = 16'd0;
    localparam logic [15:0] WALL  = 16'd1;
    localparam logic [15:0] KEY   = 16'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        move_req = 1'b0;
    logic [1:0]  move_dir = 2'd0;
    logic        busy, move_done;
    logic [7:0]  map_rd_addr;
    logic [15:0] map_rd_data;
    logic        map_wr_en;
    logic [7:0]  map_wr_addr;
    logic [15:0] map_wr_data;
    logic [15:0] tile_id;
    logic [3:0]  pos_x, pos_y, player_x, player_y, key_num;
    logic [3:0]  goto_x, goto_y, key_num_in;
    logic [15:0] step_count;

    int checks = 0;
    int errors = 0;

    player_move_ctrl #(
        .MAP_W(16), .MAP_H(16), .START_X(1), .START_Y(1),
        .FLOOR_TILE(FLOOR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .move_req(move_req), .move_dir(move_dir),
        .busy(busy), .move_done(move_done),
        .map_rd_addr(map_rd_addr), .map_rd_data(map_rd_data),
        .map_wr_en(map_wr_en), .map_wr_addr(map_wr_addr),
        .map_wr_data(map_wr_data),
        .tile_id(tile_id), .pos_x(pos_x), .pos_y(pos_y),
        .player_x(player_x), .player_y(player_y), .key_num(key_num),
        .goto_x(goto_x), .goto_y(goto_y), .key_num_in(key_num_in),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    // Map RAM: read data follows the registered address within the cycle.
    logic [15:0] mem [256];
    assign map_rd_data = mem[map_rd_addr];
    always @(posedge clk) begin
        if (map_wr_en) mem[map_wr_addr] <= map_wr_data;
    end

    // Stand-in for mux_tiles: walls block, keys are counted (4-bit).
    always_comb begin
        goto_x     = pos_x;
        goto_y     = pos_y;
        key_num_in = key_num;
        if (tile_id == WALL) begin
            goto_x = player_x;
            goto_y = player_y;
        end
        if (tile_id == KEY) key_num_in = key_num + 4'd1;
    end

    // Reference model state.
    logic [15:0] ref_map [16][16];
    int mx, my, mk, ms;

    typedef struct packed {
        logic [3:0]  px;
        logic [3:0]  py;
        logic [3:0]  kn;
        logic        wr;
        logic [7:0]  wa;
        logic [15:0] sc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, req, $time);
        end
    endtask

    function automatic logic [15:0] exp_steps(input int s);
`ifdef STEP_COUNTER_EN
        return 16'(s);
`else
        return 16'd0 + 16'(s * 0);
`endif
    endfunction

    // Monitor: every committed move is compared against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (map_wr_en && !move_done) begin
                checks++;
                errors++;
                $display("FAIL wr_without_done at %0t", $time);
            end
            if (move_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_move_done at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("player_x", 32'(player_x), 32'(e.px));
                    chk("player_y", 32'(player_y), 32'(e.py));
                    chk("key_num", 32'(key_num), 32'(e.kn));
                    chk("wr_en", 32'(map_wr_en), 32'(e.wr));
                    if (e.wr) begin
                        chk("wr_addr", 32'(map_wr_addr), 32'(e.wa));
                        chk("wr_data", 32'(map_wr_data), 32'(FLOOR));
                    end
                    chk("step_count", 32'(step_count), 32'(e.sc));
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_player_x"}, 32'(player_x), 32'd1);
        chk({tag, "_player_y"}, 32'(player_y), 32'd1);
        chk({tag, "_key_num"}, 32'(key_num), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_move_done"}, 32'(move_done), 32'd0);
        chk({tag, "_wr_en"}, 32'(map_wr_en), 32'd0);
        chk({tag, "_rd_addr"}, 32'(map_rd_addr), 32'd0);
        chk({tag, "_tile_id"}, 32'(tile_id), 32'd0);
        chk({tag, "_pos"}, 32'({pos_y, pos_x}), 32'd0);
        chk({tag, "_steps"}, 32'(step_count), 32'd0);
    endtask

    task automatic target(input logic [1:0] d, output bit ok,
                          output int tx, output int ty);
        tx = mx;
        ty = my;
        case (d)
            2'd0: ty = my - 1;
            2'd1: ty = my + 1;
            2'd2: tx = mx - 1;
            default: tx = mx + 1;
        endcase
        ok = (tx >= 0) && (tx < 16) && (ty >= 0) && (ty < 16);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, idle.
    task automatic do_move(input logic [1:0] d, input bit hold);
        bit ok;
        int tx, ty, nx, ny;
        logic [15:0] t;
        exp_t e;
        target(d, ok, tx, ty);
        move_req = 1'b1;
        move_dir = d;
        if (!ok) begin
            @(negedge clk);
            move_req = 1'b0;
            chk("drop_busy", 32'(busy), 32'd0);
            repeat (2) @(negedge clk);
            chk("drop_no_done", 32'(move_done), 32'd0);
            return;
        end
        t = ref_map[ty][tx];
        nx = (t == WALL) ? mx : tx;
        ny = (t == WALL) ? my : ty;
        e.wr = 1'b0;
        if (t == KEY && mk < 15) begin
            mk++;
            e.wr = 1'b1;
            ref_map[ty][tx] = FLOOR;
        end
        if ((nx != mx || ny != my) && ms < 65535) ms++;
        mx = nx;
        my = ny;
        e.px = 4'(mx);
        e.py = 4'(my);
        e.kn = 4'(mk);
        e.wa = 8'(ty * 16 + tx);
        e.sc = exp_steps(ms);
        exp_q.push_back(e);
        @(negedge clk);
        chk("rd_addr", 32'(map_rd_addr), 32'(ty * 16 + tx));
        chk("busy", 32'(busy), 32'd1);
        if (hold) move_dir = 2'($urandom_range(0, 3));
        else move_req = 1'b0;
        @(negedge clk);
        move_req = 1'b0;
        @(negedge clk);
        chk("latency_done", 32'(move_done), 32'd1);
    endtask

    task automatic reset_mid_move();
        bit ok;
        int tx, ty;
        for (int d = 0; d < 4; d++) begin
            target(2'(d), ok, tx, ty);
            if (ok) begin
                move_req = 1'b1;
                move_dir = 2'(d);
                break;
            end
        end
        @(negedge clk);
        move_req = 1'b0;
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("abort");
        mx = 1;
        my = 1;
        mk = 0;
        ms = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("post_abort");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                r = int'($urandom_range(0, 99));
                ref_map[y][x] = (r < 15) ? WALL : (r < 45) ? KEY : FLOOR;
            end
        end
        ref_map[1][1] = FLOOR;
        ref_map[1][2] = FLOOR;
        ref_map[0][2] = WALL;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                mem[y * 16 + x] = ref_map[y][x];
            end
        end
        mx = 1;
        my = 1;
        mk = 0;
        ms = 0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        do_move(2'd3, 1'b0);
        do_move(2'd0, 1'b0);
        for (int i = 0; i < 1200; i++) begin
            if (i == 900) reset_mid_move();
            do_move(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end
        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
